// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared digit codes and controller state encoding
package seg_disp_pkg;
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FORMAT = 2'd2} state_t;
endpackage

// File: rtl/seg_disp_ctrl_add3.sv
// bcd_add3: double-dabble digit corrector, adds 3 to digits of 5 or more
module bcd_add3 (
  input  logic [3:0] a,
  output logic [3:0] y
);
  assign y = (a >= 4'd5) ? a + 4'd3 : a;
endmodule

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: binary to signed, blanked seven-segment digit codes via serial double-dabble
module seg_disp_ctrl
  import seg_disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_signed,
  output logic [4*DIGITS-1:0]   codes,
  output logic                  done,
  output logic                  ovf
);
  localparam int BW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [BW-1:0] bcd, bcd_adj;
  logic [WIDTH-1:0] mag;
  logic neg, fmt_ovf;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] fmt_codes;
  int m;
  assign in_ready = state == IDLE;
  for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.a(bcd[4*g+:4]), .y(bcd_adj[4*g+:4]));
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: one transfer, WIDTH shifts, one format cycle
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = in_valid ? SHIFT : IDLE;
    else if (state == SHIFT) state_nx = (cnt == CW'(1)) ? FORMAT : SHIFT;
  end
  // locate leading digit, decide overflow, and build blanked/signed codes
  always_comb begin
    m = 0;
    for (int i = 0; i < DIGITS; i++) if (bcd[4*i+:4] != 4'd0) m = i;
    fmt_ovf = (bcd[4*DIGITS+:4] != 4'd0) || (neg && m == DIGITS - 1);
    fmt_codes = '0;
    for (int i = 0; i < DIGITS; i++)
      fmt_codes[4*i+:4] = fmt_ovf ? CODE_MINUS :
                          (i <= m) ? bcd[4*i+:4] :
                          (i == m + 1 && neg) ? CODE_MINUS : CODE_BLANK;
  end
  // datapath: latch magnitude, shift through correctors, publish codes at FORMAT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcd <= '0;
      mag <= '0;
      neg <= 1'b0;
      cnt <= '0;
      codes <= {DIGITS{CODE_BLANK}};
      done <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= state == FORMAT;
      if (state == IDLE && in_valid) begin
        neg <= in_signed & in_data[WIDTH-1];
        mag <= (in_signed & in_data[WIDTH-1]) ? ~in_data + 1'b1 : in_data;
        bcd <= '0;
        cnt <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
        cnt <= cnt - 1'b1;
      end else if (state == FORMAT) begin
        codes <= fmt_codes;
        ovf <= fmt_ovf;
      end
    end
endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Sequential controller that turns an ALU result into per-digit codes for a row of seven-segment decoder instances, one decoder per digit.
- Converts the binary value to BCD with iterative double-dabble, one bit per cycle, and handles signed/unsigned interpretation.
- Applies leading-zero blanking, places the minus sign and flags overflow.
- Sits between the ALU result register and the display decoders. Displayed codes change only when a conversion completes, so the display never flickers.

Parameters:
- WIDTH, 8, bit width of in_data.
- DIGITS, 4, number of display digits driven.
- Constraint: 2^WIDTH <= 10^(DIGITS+1). The internal BCD register holds DIGITS+1 digits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  request to convert in_data
- in_ready  output  1  high only in IDLE; a transfer occurs when in_valid && in_ready at a rising edge
- in_data  input  WIDTH  value to display
- in_signed  input  1  1 = in_data is two's complement, 0 = unsigned; sampled with in_data
- codes  output  4*DIGITS  digit codes; codes[4i+3:4i] is digit i, i=0 least significant. 0-9 = numeral, 10 = minus, 15 = blank
- done  output  1  one-cycle pulse when codes are updated
- ovf  output  1  last conversion did not fit; held until the next done

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, done=0, ovf=0.
  - All codes=15 (blank).
  - Any conversion in progress is aborted and discarded.
- States: IDLE -> SHIFT -> FORMAT -> IDLE.
- IDLE:
  - in_ready=1.
  - On transfer, latch neg = in_signed & in_data[WIDTH-1].
  - Latch magnitude = neg ? (~in_data + 1) as WIDTH-bit unsigned : in_data. Signed minimum, e.g. 8'h80, gives magnitude 128.
  - Clear the BCD register, load bit counter = WIDTH, go to SHIFT.
- SHIFT: exactly WIDTH cycles.
  - Each cycle: every BCD digit >= 5 gets +3, then {bcd, mag} shifts left by 1 and the counter decrements.
  - When the counter reaches 0, go to FORMAT.
- FORMAT: one cycle.
  - Let m = index of the most significant nonzero BCD digit (m=0 if the value is 0).
  - Overflow conditions:
    - BCD digit DIGITS is nonzero, or
    - neg and m = DIGITS-1.
  - On overflow: all codes=10, ovf=1.
  - Otherwise ovf=0 and:
    - digits 0..m show their BCD value;
    - digit m+1 = 10 if neg, else 15;
    - all higher digits = 15.
  - Zero is never negative.
  - done=1 for the following cycle; go to IDLE.
- Latency: a transfer at edge E0 gives updated codes and done=1 after edge E(WIDTH+1), i.e. 9 edges for WIDTH=8.
- in_ready=1 during the done cycle, so back-to-back transfers are permitted.
- in_valid and in_data are ignored while in_ready=0. No queuing.
- codes and ovf change only at the FORMAT edge or on reset.

Decomposition:
- Shared package seg_disp_pkg:
  - CODE_MINUS=4'd10, CODE_BLANK=4'd15;
  - state encoding IDLE=2'd0, SHIFT=2'd1, FORMAT=2'd2.
- One sub-module, bcd_add3: a 4-bit combinational digit corrector (out = in>=5 ? in+3 : in), instantiated DIGITS+1 times in the shift path.
- The seven-segment decoders are instantiated by the parent, not inside this block.

Test Plan:
- Reset: rst=1 mid-run, then released -> codes=16'hFFFF, done=0, ovf=0, in_ready=1.
- Unsigned zero: in_signed=0, in_data=8'h00 -> 9 edges later codes=16'hFFF0, done pulses for exactly 1 cycle, ovf=0.
- Signed negative:
  - in_signed=1, 8'hF6 -> codes=16'hFA10 ("-10").
  - in_signed=1, 8'h80 -> codes=16'hA128.
- Unsigned max: in_signed=0, 8'hFF -> codes=16'hF255. in_valid held high with other data during SHIFT is ignored, and in_ready=0 for those cycles.
- Overflow (DIGITS=3):
  - signed 8'h80 -> codes=12'hAAA, ovf=1.
  - Next, unsigned 8'hFF -> codes=12'h255, ovf=0.
- Reset mid-conversion: assert rst at SHIFT cycle 4 -> codes blank immediately (async), no done pulse. A new transfer afterwards completes normally in 9 edges.
